// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
//
// Shared definitions for the debug UART path (memory dump engine and the
// byte-to-UART formatter).
//   - dump_state_t : state encoding of the instruction-memory dump engine
//   - CH_*         : ASCII control/separator characters used in dump lines
//   - LINE_LEN     : characters per dumped word ("AAAAAAAA:DDDDDDDD\r\n")
//   - *_IDX        : character positions inside one line
//   - nibble_of()  : picks hex digit 'pos' of a word, MSB nibble first
// -----------------------------------------------------------------------------
package dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } dump_state_t;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam int LINE_LEN = 19;

  // Character positions: 0..7 address digits, 8 colon, 9..16 data digits,
  // 17 CR, 18 LF.
  localparam logic [4:0] COLON_IDX = 5'd8;
  localparam logic [4:0] CR_IDX    = 5'd17;
  localparam logic [4:0] LAST_IDX  = 5'(LINE_LEN - 1);

  // pos 0 selects bits [31:28], pos 7 selects bits [3:0]; (7-pos)*4 is the
  // bit-inverted pos followed by two zero bits.
  function automatic logic [3:0] nibble_of(input logic [31:0] w,
                                           input logic [2:0]  pos);
    return w[{~pos, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/hexchar.sv
// -----------------------------------------------------------------------------
// hexchar
//
// Combinational 4-bit nibble to uppercase ASCII hex digit.
//   nibble : value 0..15
//   ascii  : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
// Shared by the dump engine and the byte-to-UART formatter.
// -----------------------------------------------------------------------------
module hexchar (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      // 'A' (0x41) minus 10 gives the base for the letter digits.
      ascii = 8'h37 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/imem_dump_uart.sv
// -----------------------------------------------------------------------------
// imem_dump_uart
//
// Debug read-back engine for instruction memory. On trig it reads 'count'
// consecutive words starting at 'startaddr' and sends each one to the debug
// UART transmitter as the ASCII line "AAAAAAAA:DDDDDDDD\r\n". While a dump is
// running 'busy' is high; it is ORed into the debug clock suppression so the
// core stays frozen.
//
// Ports:
//   clk       : CPU clock
//   n_rst     : asynchronous active-low reset
//   trig      : start pulse, only honoured in IDLE
//   startaddr : byte address of the first word (bits [1:0] ignored)
//   count     : number of words to dump (0 gives an immediate done)
//   abort     : cancel the dump at once, no done pulse
//   r_en      : memory read enable (one cycle per word)
//   r_addr    : memory read byte address (the address register)
//   r_data    : memory read data, valid the cycle after r_en
//   charout   : character presented to the UART transmitter
//   uarttxen  : one-cycle character strobe
//   uartbusy  : UART transmitter busy, rises the cycle after uarttxen
//   busy      : dump in progress
//   done      : one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module imem_dump_uart
  import dbg_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            trig,
  input  logic [31:0]     startaddr,
  input  logic [CNTW-1:0] count,
  input  logic            abort,
  output logic            r_en,
  output logic [31:0]     r_addr,
  input  logic [31:0]     r_data,
  output logic [7:0]      charout,
  output logic            uarttxen,
  input  logic            uartbusy,
  output logic            busy,
  output logic            done
);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  dump_state_t     state_q, state_d;
  logic [31:0]     addr_q,  addr_d;
  logic [31:0]     word_q,  word_d;
  logic [4:0]      idx_q,   idx_d;
  logic [CNTW-1:0] rem_q,   rem_d;

  // Next-cycle values of the registered outputs.
  logic            txen_d;
  logic [7:0]      char_d;

  // Character generation
  logic [3:0]      addr_nib;
  logic [3:0]      word_nib;
  logic [7:0]      addr_hex;
  logic [7:0]      word_hex;

  assign r_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    idx_d   = idx_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (trig && !abort) begin
          addr_d  = startaddr & 32'hFFFF_FFFC;
          rem_d   = count;
          idx_d   = '0;
          state_d = (count == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        word_d  = r_data;
        idx_d   = '0;
        state_d = S_SEND;
      end

      // The strobe for this character was decided on entry (see txen_d), so
      // leaving SEND is keyed on the strobe actually being out.
      S_SEND: begin
        if (uarttxen) begin
          state_d = S_GAP;
        end
      end

      // One dead cycle so that uartbusy has risen before WAIT looks at it.
      S_GAP: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!uartbusy) begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 5'd1;
            state_d = S_SEND;
          end else if (rem_q > CNTW'(1)) begin
            addr_d  = addr_q + 32'd4;  // wraps modulo 2^32
            rem_d   = rem_q - CNTW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including a trig seen in IDLE.
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Character mux, evaluated on the next-cycle index/address/word so the
  // character is registered together with its strobe. On the LATCH->SEND
  // step this makes the freshly read word visible to the mux one cycle early.
  // ---------------------------------------------------------------------------
  assign addr_nib = nibble_of(addr_d, idx_d[2:0]);
  // Data digits occupy idx 9..16; their low three bits minus one give 0..7.
  assign word_nib = nibble_of(word_d, idx_d[2:0] - 3'd1);

  hexchar u_addr_hex (
    .nibble (addr_nib),
    .ascii  (addr_hex)
  );

  hexchar u_word_hex (
    .nibble (word_nib),
    .ascii  (word_hex)
  );

  always_comb begin
    char_d = 8'h00;
    if (idx_d < COLON_IDX) begin
      char_d = addr_hex;
    end else if (idx_d == COLON_IDX) begin
      char_d = CH_COLON;
    end else if (idx_d < CR_IDX) begin
      char_d = word_hex;
    end else if (idx_d == CR_IDX) begin
      char_d = CH_CR;
    end else begin
      char_d = CH_LF;
    end
  end

  // A strobe is issued in the first SEND cycle whose preceding cycle saw the
  // UART idle. uartbusy only rises after our own strobe, so an idle UART one
  // cycle earlier is still idle when the strobe appears.
  assign txen_d = (state_d == S_SEND) && !uartbusy;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      // NOTE: word/idx/rem are plain flops, not a memory array, so they are
      // cheap to reset and a dump never starts from stale contents.
      word_q   <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      r_en     <= 1'b0;
      charout  <= 8'h00;
      uarttxen <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, regardless of statement order.
      state_q  <= state_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      r_en     <= (state_d == S_FETCH);
      uarttxen <= txen_d;
      // charout holds its value between strobes.
      if (txen_d) begin
        charout <= char_d;
      end
      // busy is already low in the DONE cycle, alongside the done pulse.
      busy     <= !(state_d inside {S_IDLE, S_DONE});
      done     <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_imem_dump_uart.sv
// -----------------------------------------------------------------------------
// tb_imem_dump_uart
//
// Directed bench for imem_dump_uart: a small instruction-memory model with
// one-cycle read latency, a UART transmitter model whose busy time is set by
// busy_len, and monitors that log characters, read addresses and done pulses.
// -----------------------------------------------------------------------------
module tb_imem_dump_uart;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        trig;
  logic [31:0] startaddr;
  logic [15:0] count;
  logic        abort;
  logic        r_en;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [7:0]  charout;
  logic        uarttxen;
  logic        uartbusy;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_pass  = 0;

  // Model / monitor state
  int          busy_len = 1;
  int          ub_cnt;
  logic        txen_prev = 1'b0;
  logic [7:0]  rx[$];
  logic [31:0] raddr_log[$];
  int          ren_cnt  = 0;
  int          done_cnt = 0;
  int          viol_cnt = 0;

  localparam string L0  = "00000000:DEADBEEF\r\n";
  localparam string L10 = "00000010:12345678\r\n";
  localparam string L14 = "00000014:9ABCDEF0\r\n";
  localparam string L18 = "00000018:0F1E2D3C\r\n";
  localparam string LFC = "FFFFFFFC:CAFEF00D\r\n";

  imem_dump_uart #(.CNTW(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .trig      (trig),
    .startaddr (startaddr),
    .count     (count),
    .abort     (abort),
    .r_en      (r_en),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .charout   (charout),
    .uarttxen  (uarttxen),
    .uartbusy  (uartbusy),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hDEAD_BEEF;
      32'h0000_0010: return 32'h1234_5678;
      32'h0000_0014: return 32'h9ABC_DEF0;
      32'h0000_0018: return 32'h0F1E_2D3C;
      32'hFFFF_FFFC: return 32'hCAFE_F00D;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // UART transmitter model: busy for busy_len cycles after each strobe.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)          ub_cnt <= 0;
    else if (uarttxen)   ub_cnt <= busy_len;
    else if (ub_cnt > 0) ub_cnt <= ub_cnt - 1;
  end
  assign uartbusy = (ub_cnt != 0);

  // Memory model and monitors.
  always @(posedge clk) begin
    r_data <= r_en ? mem_read(r_addr) : 32'hxxxx_xxxx;
    if (uarttxen) rx.push_back(charout);
    if (r_en) begin
      ren_cnt <= ren_cnt + 1;
      raddr_log.push_back(r_addr);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (uarttxen && (uartbusy || txen_prev)) viol_cnt <= viol_cnt + 1;
    txen_prev <= uarttxen;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_r_en"},     32'(r_en),     32'd0);
    check({tag, "_r_addr"},   r_addr,        32'd0);
    check({tag, "_charout"},  32'(charout),  32'd0);
    check({tag, "_uarttxen"}, 32'(uarttxen), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
  endtask

  // Pulses trig for one cycle; returns at the negedge after the sampling edge.
  task automatic start(input logic [31:0] a, input logic [15:0] c);
    @(negedge clk);
    startaddr = a;
    count     = c;
    trig      = 1'b1;
    @(negedge clk);
    trig      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic wait_chars(input string tag, input int base, input int n,
                            input int budget);
    int k = 0;
    while (rx.size() - base < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_chars_reached"}, 32'(rx.size() - base), 32'(n));
  endtask

  task automatic check_text(input string tag, input int base, input string exp);
    logic [7:0] got;
    bit         bad;
    check({tag, "_len"}, 32'(rx.size() - base), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      got = (base + i < rx.size()) ? rx[base + i] : 8'h00;
      bad = (got !== exp[i]);
      check($sformatf("%s_chr%0d", tag, i), 32'(got), 32'(exp[i]));
      if (bad) break;
    end
  endtask

  initial begin
    int base, rb, db, lb, vb;

    n_rst     = 1'b0;
    trig      = 1'b0;
    abort     = 1'b0;
    startaddr = '0;
    count     = '0;

    // ---- Reset state ----
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // ---- Single word, fast UART, cycle-exact start ----
    busy_len = 1;
    base = rx.size(); rb = ren_cnt; db = done_cnt;
    start(32'h0, 16'd1);
    check("t1_fetch_r_en",  32'(r_en), 32'd1);
    check("t1_fetch_busy",  32'(busy), 32'd1);
    check("t1_fetch_raddr", r_addr,    32'h0);
    check("t1_fetch_txen",  32'(uarttxen), 32'd0);
    @(negedge clk);
    check("t1_latch_r_en",  32'(r_en), 32'd0);
    check("t1_latch_busy",  32'(busy), 32'd1);
    @(negedge clk);
    check("t1_first_txen",  32'(uarttxen), 32'd1);
    check("t1_first_char",  32'(charout),  32'h30);
    @(negedge clk);
    check("t1_gap_txen",    32'(uarttxen), 32'd0);
    wait_done("t1", 400);
    check_text("t1_text", base, L0);
    check("t1_ren_pulses", 32'(ren_cnt - rb),  32'd1);
    check("t1_done_pulses", 32'(done_cnt - db), 32'd1);

    // ---- count = 0 ----
    base = rx.size(); rb = ren_cnt; db = done_cnt;
    start(32'h40, 16'd0);
    check("t2_done",  32'(done), 32'd1);
    check("t2_busy",  32'(busy), 32'd0);
    check("t2_r_en",  32'(r_en), 32'd0);
    @(negedge clk);
    check("t2_done_low", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("t2_no_reads", 32'(ren_cnt - rb),    32'd0);
    check("t2_no_chars", 32'(rx.size() - base), 32'd0);
    check("t2_one_done", 32'(done_cnt - db),   32'd1);

    // ---- Three words, slow UART, unaligned start address ----
    busy_len = 10;
    base = rx.size(); db = done_cnt; lb = raddr_log.size(); vb = viol_cnt;
    start(32'h13, 16'd3);
    wait_done("t3", 3000);
    check_text("t3_text", base, {L10, L14, L18});
    check("t3_reads", 32'(raddr_log.size() - lb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_raddr%0d", i),
            (lb + i < raddr_log.size()) ? raddr_log[lb + i] : 32'hFFFF_FFFF,
            32'h10 + 32'(4 * i));
    end
    check("t3_strobe_rules", 32'(viol_cnt - vb), 32'd0);
    check("t3_done_pulses",  32'(done_cnt - db), 32'd1);

    // ---- Address wrap-around ----
    busy_len = 1;
    base = rx.size();
    start(32'hFFFF_FFFC, 16'd2);
    wait_done("t4", 800);
    check_text("t4_text", base, {LFC, L0});

    // ---- Abort mid-line, ignored trig during dump, clean restart ----
    base = rx.size(); db = done_cnt;
    start(32'h10, 16'd3);
    wait_chars("t5_pre", base, 10, 200);
    start(32'h0, 16'd1);                    // ignored: not in IDLE
    wait_chars("t5", base, 24, 200);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy_after_abort", 32'(busy), 32'd0);
    check("t5_txen_after_abort", 32'(uarttxen), 32'd0);
    repeat (60) @(negedge clk);
    check_text("t5_text", base, {L10, "00000"});
    check("t5_no_done", 32'(done_cnt - db), 32'd0);

    @(negedge clk);
    startaddr = 32'h0; count = 16'd1; trig = 1'b1; abort = 1'b1;
    @(negedge clk);
    trig = 1'b0; abort = 1'b0;
    check("t5_trig_abort_busy", 32'(busy), 32'd0);
    check("t5_trig_abort_r_en", 32'(r_en), 32'd0);

    base = rx.size();
    start(32'h0, 16'd1);
    wait_done("t5_restart", 400);
    check_text("t5_restart_text", base, L0);

    // ---- Asynchronous reset during WAIT ----
    busy_len = 10;
    base = rx.size();
    start(32'h14, 16'd1);
    wait_chars("t6", base, 3, 200);
    repeat (3) @(negedge clk);
    check("t6_busy_before_reset", 32'(busy), 32'd1);
    #2 n_rst = 1'b0;
    #1 check_outputs_zero("t6_async");
    @(negedge clk);
    n_rst = 1'b1;
    busy_len = 1;
    base = rx.size();
    start(32'h0, 16'd1);
    wait_done("t6_restart", 400);
    check_text("t6_restart_text", base, L0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
